// File: rtl/bubble_outbuf_loader_if.sv
// rtl/bubble_outbuf_loader_if.sv - byte-fetch handshake and output-buffer write port bundle
interface bubble_outbuf_loader_if;
    logic        byte_req;
    logic [19:0] byte_addr;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        n_outbuf_wclken;
    logic [14:0] outbuf_waddr;
    logic        outbuf_wdata;

    modport master (
        output byte_req, byte_addr, n_outbuf_wclken, outbuf_waddr, outbuf_wdata,
        input  byte_valid, byte_data
    );

    modport slave (
        input  byte_req, byte_addr, n_outbuf_wclken, outbuf_waddr, outbuf_wdata,
        output byte_valid, byte_data
    );
endinterface

// File: rtl/bubble_outbuf_loader.sv
// rtl/bubble_outbuf_loader.sv - fills the bubble output buffer with the boot image or one user page
// Optional write stall during buffer reads: define OUTBUF_READ_GUARD_EN.
module bubble_outbuf_loader #(
    parameter int BOOT_BYTES = 480,
    parameter int PAGE_BYTES = 146
) (
    input  logic                          i_mclk,
    input  logic                          i_rst,
    input  logic                          i_load_req,
    input  logic                          i_load_type,
    input  logic [10:0]                   i_page_num,
    input  logic [2:0]                    i_acctype,
    bubble_outbuf_loader_if.master        io_bus,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam logic [14:0] BOOT_SYNC_FIRST = 15'd3972;
    localparam logic [14:0] BOOT_SYNC_END   = 15'd4102;
    localparam logic [14:0] BOOT_LEAD_LAST  = 15'd4105;
    localparam logic [14:0] BOOT_LAST       = 15'(4106 + 8 * BOOT_BYTES + 265);
    localparam logic [14:0] USER_FIRST      = 15'd14336;
    localparam logic [14:0] USER_LEAD_LAST  = 15'd14341;
    localparam logic [14:0] USER_TAIL_FIRST = 15'd16380;
    localparam logic [14:0] USER_LAST       = 15'd16383;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_FETCH, S_SHIFT, S_TAIL, S_FINISH
    } state_t;

    state_t      r_state;
    logic        r_type;
    logic [10:0] r_page;
    logic [14:0] r_idx;
    logic [7:0]  r_byte;
    logic [2:0]  r_bit;
    logic [9:0]  r_bytes_left;
    logic        r_nwclken;
    logic [14:0] r_waddr;
    logic        r_wdata;
    logic        r_byte_req;
    logic [19:0] r_byte_addr;
    logic        r_busy;
    logic        r_done;

    logic        w_stall;
    logic [14:0] w_lead_idx;
    logic        w_lead_type;
    logic        w_lead_bit;
    logic [14:0] w_lead_last;
    logic        w_tail_last;
    logic [19:0] w_user_base;
    logic        w_shift_bit;
    logic        w_issue;
    logic [14:0] w_wr_idx;
    logic        w_wr_logical;

`ifdef OUTBUF_READ_GUARD_EN
    assign w_stall = (i_acctype == 3'b110) || (i_acctype == 3'b111);
`else
    logic w_unused_acctype;
    assign w_unused_acctype = ^i_acctype;
    assign w_stall = 1'b0;
`endif

    // The very first write is issued from IDLE so it lands in the cycle BUSY rises.
    assign w_lead_idx  = (r_state == S_IDLE) ? (i_load_type ? USER_FIRST : 15'd0) : r_idx;
    assign w_lead_type = (r_state == S_IDLE) ? i_load_type : r_type;
    assign w_lead_bit  = w_lead_type ? 1'b0 :
                         ((w_lead_idx >= BOOT_SYNC_FIRST) && (w_lead_idx < BOOT_SYNC_END)) ? w_lead_idx[0] :
                         1'b1;
    assign w_lead_last = r_type ? USER_LEAD_LAST : BOOT_LEAD_LAST;
    assign w_tail_last = r_type ? (r_idx == USER_LAST) : (r_idx == BOOT_LAST);
    assign w_user_base = 20'(BOOT_BYTES) + 20'(r_page) * 20'(PAGE_BYTES);
    assign w_shift_bit = r_byte[3'd7 - r_bit];

    always_comb begin
        w_issue      = 1'b0;
        w_wr_idx     = r_idx;
        w_wr_logical = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue      = i_load_req && !w_stall;
                w_wr_idx     = w_lead_idx;
                w_wr_logical = w_lead_bit;
            end
            S_LEAD: begin
                w_issue      = !w_stall;
                w_wr_logical = w_lead_bit;
            end
            S_FETCH: begin
                w_issue      = r_byte_req && io_bus.byte_valid && !w_stall;
                w_wr_logical = io_bus.byte_data[7];
            end
            S_SHIFT: begin
                w_issue      = !w_stall;
                w_wr_logical = w_shift_bit;
            end
            S_TAIL: begin
                w_issue      = !w_stall;
                w_wr_logical = ~r_type;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_type       <= 1'b0;
            r_page       <= '0;
            r_idx        <= '0;
            r_byte       <= '0;
            r_bit        <= '0;
            r_bytes_left <= '0;
            r_nwclken    <= 1'b1;
            r_waddr      <= '0;
            r_wdata      <= 1'b0;
            r_byte_req   <= 1'b0;
            r_byte_addr  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_nwclken <= 1'b1;
            r_done    <= 1'b0;
            if (w_issue) begin
                r_nwclken <= 1'b0;
                r_waddr   <= w_wr_idx;
                r_wdata   <= ~w_wr_logical;
                r_idx     <= w_wr_idx + 15'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_load_req) begin
                        r_type  <= i_load_type;
                        r_page  <= i_page_num;
                        r_busy  <= 1'b1;
                        r_state <= S_LEAD;
                        if (w_stall) begin
                            r_idx <= w_lead_idx;
                        end
                    end
                end
                S_LEAD: begin
                    if (!w_stall && (r_idx == w_lead_last)) begin
                        r_state      <= S_FETCH;
                        r_byte_addr  <= r_type ? w_user_base : 20'd0;
                        r_bytes_left <= r_type ? 10'(PAGE_BYTES) : 10'(BOOT_BYTES);
                    end
                end
                S_FETCH: begin
                    // Request rises one cycle after the last write so it never overlaps a write.
                    if (!r_byte_req) begin
                        r_byte_req <= 1'b1;
                    end else if (io_bus.byte_valid) begin
                        r_byte_req   <= 1'b0;
                        r_byte       <= io_bus.byte_data;
                        r_byte_addr  <= r_byte_addr + 20'd1;
                        r_bytes_left <= r_bytes_left - 10'd1;
                        r_bit        <= w_stall ? 3'd0 : 3'd1;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_stall) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (r_bytes_left != 10'd0) begin
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_TAIL;
                                if (r_type) begin
                                    r_idx <= USER_TAIL_FIRST;
                                end
                            end
                        end
                    end
                end
                S_TAIL: begin
                    if (!w_stall && w_tail_last) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.byte_req        = r_byte_req;
    assign io_bus.byte_addr       = r_byte_addr;
    assign io_bus.n_outbuf_wclken = r_nwclken;
    assign io_bus.outbuf_waddr    = r_waddr;
    assign io_bus.outbuf_wdata    = r_wdata;
    assign o_busy                 = r_busy;
    assign o_done                 = r_done;

endmodule
